// File: rtl/serial_pattern_tx.sv
// Framed serializer: start bit, WIDTH data bits MSB-first, optional even parity, stop bit.
// Every output comes straight from a flop, so each one is computed from the next state.
module serial_pattern_tx #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  // states: IDLE wait for load | START start bit | SHIFT data bits | PARITY parity bit | STOP stop bit
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             ready_q, ready_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d = data_in;
          par_d   = ^data_in;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = CW'(WIDTH - 1);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = PARITY_EN ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PARITY: state_d = S_STOP;
      S_STOP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    x_d     = IDLE_LVL;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_IDLE: begin
        ready_d = 1'b1;
        done_d  = (state_q == S_STOP);
      end
      S_START: begin
        x_d     = 1'b1;
        valid_d = 1'b1;
      end
      S_SHIFT: begin
        x_d     = shift_d[WIDTH-1];
        valid_d = 1'b1;
      end
      S_PARITY: begin
        x_d     = par_d;
        valid_d = 1'b1;
      end
      S_STOP: begin
        x_d     = 1'b0;
        valid_d = 1'b1;
      end
      default: begin
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      ready_q <= 1'b1;
      x_q     <= IDLE_LVL;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      ready_q <= ready_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign ready   = ready_q;
  assign x       = x_q;
  assign x_valid = valid_q;
  assign busy    = valid_q;
  assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: one parity-enabled and one parity-disabled instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_a, load_b;
  logic [7:0] data_a, data_b;
  logic       ready_a, x_a, xv_a, busy_a, done_a;
  logic       ready_b, x_b, xv_b, busy_b, done_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .PARITY_EN(1'b1), .IDLE_LVL(1'b0)) dut_par (
    .clk(clk), .reset_n(reset_n), .data_in(data_a), .load(load_a),
    .ready(ready_a), .x(x_a), .x_valid(xv_a), .busy(busy_a), .done(done_a)
  );

  serial_pattern_tx #(.WIDTH(8), .PARITY_EN(1'b0), .IDLE_LVL(1'b0)) dut_np (
    .clk(clk), .reset_n(reset_n), .data_in(data_b), .load(load_b),
    .ready(ready_b), .x(x_b), .x_valid(xv_b), .busy(busy_b), .done(done_b)
  );

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic start_frame(input bit np, input logic [7:0] d);
    if (np) begin load_b = 1'b1; data_b = d; end
    else    begin load_a = 1'b1; data_a = d; end
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  // Entered at the first x_valid cycle; returns at the cycle after the last frame bit.
  task automatic chk_frame(input logic [10:0] bits, input int len, input bit np,
                           input string tag, input int ghost_at, input bit arm_end);
    for (int i = 0; i < len; i++) begin
      check_eq({tag, "_x"}, np ? x_b : x_a, bits[len-1-i]);
      check_eq({tag, "_vld"}, np ? xv_b : xv_a, 1'b1);
      check_eq({tag, "_busy"}, np ? busy_b : busy_a, 1'b1);
      check_eq({tag, "_rdy"}, np ? ready_b : ready_a, 1'b0);
      if (ghost_at >= 0 && i == ghost_at) begin load_a = 1'b1; data_a = 8'h00; end
      if (ghost_at >= 0 && i == ghost_at + 1) begin load_a = 1'b0; data_a = 8'h3C; end
      if (arm_end && i == len - 1) load_a = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic chk_done(input bit np, input string tag);
    check_eq({tag, "_done"}, np ? done_b : done_a, 1'b1);
    check_eq({tag, "_done_vld"}, np ? xv_b : xv_a, 1'b0);
    check_eq({tag, "_done_rdy"}, np ? ready_b : ready_a, 1'b1);
    check_eq({tag, "_done_x"}, np ? x_b : x_a, 1'b0);
  endtask

  task automatic chk_quiet(input bit np, input string tag);
    check_eq({tag, "_q_done"}, np ? done_b : done_a, 1'b0);
    check_eq({tag, "_q_vld"}, np ? xv_b : xv_a, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    load_a  = 1'b1;
    load_b  = 1'b1;
    data_a  = 8'hA5;
    data_b  = 8'hFF;

    // reset held with load high
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_rdy", ready_a, 1'b1);
      check_eq("rst_x", x_a, 1'b0);
      check_eq("rst_vld", xv_a, 1'b0);
      check_eq("rst_done", done_a, 1'b0);
      check_eq("rst_vld_np", xv_b, 1'b0);
    end
    reset_n = 1'b1;
    load_a  = 1'b0;
    load_b  = 1'b0;
    @(negedge clk);
    check_eq("post_rst_vld", xv_a, 1'b0);
    check_eq("post_rst_rdy", ready_a, 1'b1);
    check_eq("post_rst_vld_np", xv_b, 1'b0);

    // A5, parity 0
    start_frame(1'b0, 8'hA5);
    chk_frame(11'b1_10100101_0_0, 11, 1'b0, "a5", -1, 1'b0);
    chk_done(1'b0, "a5");
    @(negedge clk);
    chk_quiet(1'b0, "a5");

    // 07, parity 1
    start_frame(1'b0, 8'h07);
    chk_frame(11'b1_00000111_1_0, 11, 1'b0, "p07", -1, 1'b0);
    chk_done(1'b0, "p07");
    @(negedge clk);
    chk_quiet(1'b0, "p07");

    // FF without parity: 10-bit frame
    start_frame(1'b1, 8'hFF);
    chk_frame(11'b0_1_11111111_0, 10, 1'b1, "ff_np", -1, 1'b0);
    chk_done(1'b1, "ff_np");
    @(negedge clk);
    chk_quiet(1'b1, "ff_np");

    // mid-frame load ignored, then load held through done re-arms with 3C
    start_frame(1'b0, 8'h81);
    chk_frame(11'b1_10000001_0_0, 11, 1'b0, "f81", 3, 1'b1);
    chk_done(1'b0, "f81");
    @(negedge clk);
    load_a = 1'b0;
    chk_frame(11'b1_00111100_0_0, 11, 1'b0, "f3c", -1, 1'b0);
    chk_done(1'b0, "f3c");
    @(negedge clk);
    chk_quiet(1'b0, "f3c");

    // reset during SHIFT bit 4 aborts the frame
    start_frame(1'b0, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      check_eq("abort_vld", xv_a, 1'b1);
      if (i < 5) @(negedge clk);
    end
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("abort_vld_off", xv_a, 1'b0);
    check_eq("abort_rdy", ready_a, 1'b1);
    check_eq("abort_busy", busy_a, 1'b0);
    check_eq("abort_done", done_a, 1'b0);
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk_quiet(1'b0, "abort");
    end
    start_frame(1'b0, 8'hA5);
    chk_frame(11'b1_10100101_0_0, 11, 1'b0, "clean", -1, 1'b0);
    chk_done(1'b0, "clean");
    @(negedge clk);
    chk_quiet(1'b0, "clean");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
